// File: rtl/ioblock_cfg_pkg.sv
// Shared types and encodings for the ioblock54 pad configuration controller.
// A config word is {TSMUX[1:0], DORREG}, shifted MSB first.
package ioblock_cfg_pkg;

  localparam int CW = 3;

  localparam logic [1:0] TS_OFF   = 2'b00;
  localparam logic [1:0] TS_CTRL  = 2'b01;
  // Any TSMUX value with bit 1 set drives the pad; bit 0 is don't-care there.
  localparam logic [1:0] TS_DRIVE = 2'b10;

  localparam logic DIRECT = 1'b0;
  localparam logic REG    = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } cfg_state_e;

  typedef logic [CW-1:0] cfg_word_t;

  function automatic cfg_word_t cfg_word(input logic [1:0] tsmux, input logic dorreg);
    return {tsmux, dorreg};
  endfunction

endpackage

// File: rtl/ioblock_cfg_shifter.sv
// Parallel-load PISO with a down-counter: emits CHAIN_LEN bits MSB first,
// with se high for exactly CHAIN_LEN cycles after a load.
module ioblock_cfg_shifter #(
  parameter  int CHAIN_LEN = 12,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [CHAIN_LEN-1:0] data_i,
  output logic                 sdo_o,
  output logic                 se_o,
  output logic                 last_o
);

  logic [CHAIN_LEN-1:0] sreg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 se_q;
  logic                 sdo_q;

  // sdo_q holds the bit currently on the wire; sreg_q holds the bits still to go.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      se_q   <= 1'b0;
      sdo_q  <= 1'b0;
    end else if (load_i) begin
      sreg_q <= data_i << 1;
      sdo_q  <= data_i[CHAIN_LEN-1];
      se_q   <= 1'b1;
      cnt_q  <= CNT_W'(CHAIN_LEN - 1);
    end else if (se_q) begin
      if (cnt_q == '0) begin
        se_q  <= 1'b0;
        sdo_q <= 1'b0;
      end else begin
        sdo_q  <= sreg_q[CHAIN_LEN-1];
        sreg_q <= sreg_q << 1;
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  assign sdo_o  = sdo_q;
  assign se_o   = se_q;
  assign last_o = se_q && (cnt_q == '0);

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// Pad configuration controller: shadow image of NUM_IO config words, serially
// programmed into the pad chain on commit, followed by a one-cycle latch strobe.
module ioblock_cfg_ctrl
  import ioblock_cfg_pkg::*;
#(
  parameter  int NUM_IO    = 4,
  parameter  bit AUTO_INIT = 1'b1,
  localparam int CHAIN_LEN = CW * NUM_IO,
  localparam int AW        = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
  input  logic          IOCLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [CW-1:0] WR_DATA,
  input  logic          COMMIT,
  input  logic [AW-1:0] RD_ADDR,
  output logic [CW-1:0] RD_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          CFG_SDO,
  output logic          CFG_SE,
  output logic          CFG_LATCH,
  output cfg_state_e    DBG_STATE
);

  cfg_word_t            shadow_q [NUM_IO];
  cfg_word_t            shadow_d [NUM_IO];
  logic [CHAIN_LEN-1:0] snap_data;
  logic [CW-1:0]        rd_data;
  cfg_state_e           state_q;
  logic                 pending_q;
  logic                 latch_q;
  logic                 done_q;
  logic                 load;
  logic                 sh_last;

  // Out-of-range write addresses match no pad and are dropped.
  always_comb begin
    for (int i = 0; i < NUM_IO; i++) begin
      shadow_d[i] = shadow_q[i];
      if (WR_EN && (WR_ADDR == AW'(i))) shadow_d[i] = WR_DATA;
    end
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_IO; i++) shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Snapshot from the next-state image so a same-cycle write is forwarded.
  always_comb begin
    snap_data = '0;
    for (int i = 0; i < NUM_IO; i++) snap_data[CW*i +: CW] = shadow_d[i];
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (RD_ADDR == AW'(i)) rd_data = shadow_q[i];
    end
  end

  always_comb begin
    load = 1'b0;
    case (state_q)
      ST_INIT:  load = 1'b1;
      ST_IDLE:  load = COMMIT;
      ST_LATCH: load = pending_q || COMMIT;
      default:  load = 1'b0;
    endcase
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state_q   <= AUTO_INIT ? ST_INIT : ST_IDLE;
      pending_q <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_INIT: state_q <= ST_SHIFT;
        ST_IDLE: begin
          if (COMMIT) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (COMMIT) pending_q <= 1'b1;
          if (sh_last) begin
            state_q <= ST_LATCH;
            latch_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        ST_LATCH: begin
          pending_q <= 1'b0;
          state_q   <= (pending_q || COMMIT) ? ST_SHIFT : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ioblock_cfg_shifter #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_shifter (
    .clk_i (IOCLK),
    .rst_i (RST),
    .load_i(load),
    .data_i(snap_data),
    .sdo_o (CFG_SDO),
    .se_o  (CFG_SE),
    .last_o(sh_last)
  );

  assign RD_DATA   = rd_data;
  assign BUSY      = (state_q == ST_SHIFT) || (state_q == ST_LATCH) || pending_q;
  assign DONE      = done_q;
  assign CFG_LATCH = latch_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Directed bench for ioblock_cfg_ctrl: a NUM_IO=4 auto-init instance and a
// NUM_IO=5 instance without auto-init, sharing one clock.
module tb_ioblock_cfg_ctrl;
  import ioblock_cfg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_IO=4, AUTO_INIT=1
  logic       a_rst, a_wr_en, a_commit;
  logic [1:0] a_wr_addr, a_rd_addr;
  logic [2:0] a_wr_data, a_rd_data;
  logic       a_busy, a_done, a_sdo, a_se, a_latch;
  cfg_state_e a_state;

  // Instance B: NUM_IO=5, AUTO_INIT=0
  logic       b_rst, b_wr_en, b_commit;
  logic [2:0] b_wr_addr, b_rd_addr;
  logic [2:0] b_wr_data, b_rd_data;
  logic       b_busy, b_done, b_sdo, b_se, b_latch;
  cfg_state_e b_state;

  ioblock_cfg_ctrl #(.NUM_IO(4), .AUTO_INIT(1'b1)) dut_a (
    .IOCLK(clk), .RST(a_rst), .WR_EN(a_wr_en), .WR_ADDR(a_wr_addr),
    .WR_DATA(a_wr_data), .COMMIT(a_commit), .RD_ADDR(a_rd_addr),
    .RD_DATA(a_rd_data), .BUSY(a_busy), .DONE(a_done), .CFG_SDO(a_sdo),
    .CFG_SE(a_se), .CFG_LATCH(a_latch), .DBG_STATE(a_state)
  );

  ioblock_cfg_ctrl #(.NUM_IO(5), .AUTO_INIT(1'b0)) dut_b (
    .IOCLK(clk), .RST(b_rst), .WR_EN(b_wr_en), .WR_ADDR(b_wr_addr),
    .WR_DATA(b_wr_data), .COMMIT(b_commit), .RD_ADDR(b_rd_addr),
    .RD_DATA(b_rd_data), .BUSY(b_busy), .DONE(b_done), .CFG_SDO(b_sdo),
    .CFG_SE(b_se), .CFG_LATCH(b_latch), .DBG_STATE(b_state)
  );

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];

  typedef struct {
    bit         sel;
    bit         we;
    logic [2:0] wa;
    logic [2:0] wd;
    logic [2:0] ra;
    logic [2:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [14:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  // Call at the first SE cycle; returns at the cycle after the 12th SE cycle.
  task automatic a_stream(input string name, input logic [15:0] commit_mask,
                          input int wr_at, input logic [1:0] wa, input logic [2:0] wd);
    logic e;
    for (int k = 1; k <= 12; k++) begin
      if (exp_q.size() == 0) begin
        check({name, " scoreboard_empty"}, 32'd1, 32'd0);
        e = 1'b0;
      end else begin
        e = exp_q.pop_front();
      end
      check($sformatf("%s se[%0d]", name, k), a_se, 1);
      check($sformatf("%s sdo[%0d]", name, k), a_sdo, e);
      check($sformatf("%s busy[%0d]", name, k), a_busy, 1);
      a_commit  = commit_mask[k];
      a_wr_en   = (k == wr_at);
      a_wr_addr = wa;
      a_wr_data = wd;
      tick();
    end
    a_commit = 1'b0;
    a_wr_en  = 1'b0;
  endtask

  task automatic a_latch_check(input string name);
    check({name, " latch"}, a_latch, 1);
    check({name, " done"}, a_done, 1);
    check({name, " latch_se"}, a_se, 0);
    check({name, " latch_busy"}, a_busy, 1);
    check({name, " latch_state"}, a_state, ST_LATCH);
  endtask

  task automatic a_idle_check(input string name);
    check({name, " idle_se"}, a_se, 0);
    check({name, " idle_latch"}, a_latch, 0);
    check({name, " idle_done"}, a_done, 0);
    check({name, " idle_busy"}, a_busy, 0);
    check({name, " idle_sdo"}, a_sdo, 0);
    check({name, " idle_state"}, a_state, ST_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] exp_b;
    int          viol;

    a_rst = 1'b1; a_wr_en = 1'b0; a_commit = 1'b0;
    a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_commit = 1'b0;
    b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;

    vecs[0] = '{1'b0, 1'b1, 3'd2, 3'b011, 3'd2, 3'b011};
    vecs[1] = '{1'b0, 1'b1, 3'd0, 3'b101, 3'd0, 3'b101};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 3'b000, 3'd1, 3'b000};
    vecs[3] = '{1'b0, 1'b0, 3'd0, 3'b000, 3'd2, 3'b011};
    vecs[4] = '{1'b0, 1'b0, 3'd0, 3'b000, 3'd3, 3'b000};
    vecs[5] = '{1'b1, 1'b1, 3'd4, 3'b010, 3'd4, 3'b010};
    vecs[6] = '{1'b1, 1'b1, 3'd7, 3'b111, 3'd4, 3'b010};
    vecs[7] = '{1'b1, 1'b0, 3'd0, 3'b000, 3'd7, 3'b000};
    vecs[8] = '{1'b1, 1'b0, 3'd0, 3'b000, 3'd0, 3'b000};

    // Reset held for three edges
    repeat (3) tick();
    check("rst a_se", a_se, 0);
    check("rst a_sdo", a_sdo, 0);
    check("rst a_latch", a_latch, 0);
    check("rst a_done", a_done, 0);
    check("rst a_busy", a_busy, 0);
    check("rst a_state", a_state, ST_INIT);
    check("rst b_state", b_state, ST_IDLE);
    check("rst b_busy", b_busy, 0);
    for (int i = 0; i < 4; i++) begin
      a_rd_addr = 2'(i);
      #1;
      check($sformatf("rst a_rd[%0d]", i), a_rd_data, 0);
    end

    // Auto-init: INIT cycle, 12 zero bits, latch at cycle 14
    a_rst = 1'b0;
    b_rst = 1'b0;
    check("init cycle se", a_se, 0);
    check("init cycle busy", a_busy, 0);
    tick();
    push_stream(15'b000_000_000_000, 12);
    a_stream("init", 16'h0000, 0, 2'd0, 3'd0);
    a_latch_check("init");
    tick();
    a_idle_check("init");
    check("b stays idle", b_busy, 0);

    // Table: shadow writes and readback on both instances
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].sel == 1'b0) begin
        a_wr_en = vecs[v].we; a_wr_addr = vecs[v].wa[1:0];
        a_wr_data = vecs[v].wd; a_rd_addr = vecs[v].ra[1:0];
      end else begin
        b_wr_en = vecs[v].we; b_wr_addr = vecs[v].wa;
        b_wr_data = vecs[v].wd; b_rd_addr = vecs[v].ra;
      end
      tick();
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
      check($sformatf("vec%0d rd_data", v),
            (vecs[v].sel ? b_rd_data : a_rd_data), vecs[v].exp_rd);
    end

    // Commit in IDLE; commits at SE 5 and 9 queue one re-run; pad1 written at SE 6
    a_rd_addr = 2'd2;
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    check("run1 rd2", a_rd_data, 3'b011);
    push_stream(15'b000_011_000_101, 12);
    a_stream("run1", 16'h0220, 6, 2'd1, 3'b100);
    a_latch_check("run1");
    tick();
    push_stream(15'b000_011_100_101, 12);
    a_stream("rerun", 16'h0000, 0, 2'd0, 3'd0);
    a_latch_check("rerun");
    tick();
    a_idle_check("rerun");
    a_rd_addr = 2'd1;
    #1;
    check("rerun rd1", a_rd_data, 3'b100);

    // Same-cycle write+commit is forwarded; commit in LATCH gives immediate re-run
    a_wr_en = 1'b1; a_wr_addr = 2'd3; a_wr_data = 3'b110; a_commit = 1'b1;
    tick();
    a_wr_en = 1'b0; a_commit = 1'b0;
    push_stream(15'b110_011_100_101, 12);
    a_stream("fwd", 16'h0000, 0, 2'd0, 3'd0);
    a_latch_check("fwd");
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    push_stream(15'b110_011_100_101, 12);
    a_stream("latch_commit", 16'h0000, 0, 2'd0, 3'd0);
    a_latch_check("latch_commit");
    tick();
    a_idle_check("latch_commit");

    // Instance B: reset at SE cycle 7 aborts, pending dropped, no latch
    exp_b = 15'b010_000_000_000_000;
    b_rd_addr = 3'd4;
    b_commit = 1'b1;
    tick();
    b_commit = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("b se[%0d]", k), b_se, 1);
      check($sformatf("b sdo[%0d]", k), b_sdo, exp_b[15 - k]);
      b_commit = (k == 3);
      b_rst    = (k == 7);
      tick();
    end
    b_commit = 1'b0;
    check("b abort se", b_se, 0);
    check("b abort latch", b_latch, 0);
    check("b abort busy", b_busy, 0);
    check("b abort state", b_state, ST_IDLE);
    check("b abort rd4", b_rd_data, 0);
    b_rst = 1'b0;
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (b_se || b_latch || b_done || b_busy) viol++;
    end
    check("b post-reset quiet", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
